guvm_instr_feeder: RTL and testbench
====================================

# guvm_instr_feeder

Testbench-side instruction-memory responder that sits directly upstream of the core's instruction fetch port in the GUVM environment. The driver pushes 32-bit instruction words into an in-order FIFO. The block answers the core's fetch requests with a req/gnt/rvalid handshake and returns one buffered word per granted fetch. It also records the fetch address and counts fetches and NOP fills for the scoreboard.

## Interface
- DEPTH, 8: FIFO depth in words; power of two, minimum 2.
- STALL_ON_EMPTY, 1: 1 = withhold grant while the FIFO is empty; 0 = grant anyway and return NOP_INSTR.
- NOP_INSTR, 32'h00000013: word returned on an empty-FIFO grant when STALL_ON_EMPTY=0.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- push_valid_i  in  1  driver offers a word.
- push_instr_i  in  32  instruction word offered.
- push_ready_o  out  1  FIFO can accept a word.
- flush_i  in  1  discard all buffered words.
- instr_req_i  in  1  core fetch request.
- instr_addr_i  in  32  core fetch address.
- instr_gnt_o  out  1  fetch granted (combinational).
- instr_rvalid_o  out  1  response valid (registered).
- instr_rdata_o  out  32  response word (registered).
- last_addr_o  out  32  address of the most recent granted fetch.
- fifo_count_o  out  $clog2(DEPTH)+1  words buffered.
- fetch_count_o  out  16  granted fetches, wraps at 16'hFFFF -> 0.
- nop_count_o  out  16  NOP responses, wraps.

## Operation
- FIFO: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
  - push_ready_o = !full.
  - Push happens when push_valid_i && push_ready_o && !flush_i.
  - A push into a full FIFO is refused; the driver holds the word.
- Grant: instr_gnt_o = instr_req_i && !flush_i && (!empty || !STALL_ON_EMPTY).
  - Grant depends on current-cycle state only. There is no same-cycle push-to-grant bypass.
- On a granted cycle:
  - If non-empty: pop the head word into the response register.
  - If empty (only possible with STALL_ON_EMPTY=0): load NOP_INSTR and increment nop_count_o.
  - Capture instr_addr_i into last_addr_o.
  - Increment fetch_count_o.
- Response: instr_rvalid_o is set for exactly the one cycle after each grant. With back-to-back grants it stays high continuously.
  - The core always accepts rvalid, so there is no response backpressure.
  - At most one response is in flight.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. When full, push_ready_o is 0 even if a pop occurs that cycle.
- Flush:
  - Resets the pointers and occupancy to 0 and suppresses grant and push that cycle.
  - A response already registered still completes on the following cycle.
- States:
  - IDLE: no response pending.
  - RESP: response register valid.
  - Transitions:
    - IDLE -> RESP on grant.
    - RESP -> RESP on grant.
    - RESP -> IDLE with no grant.
  - Encoded as the instr_rvalid_o flop.

## Timing
- Reset (rst_ni low at a rising edge) clears, at that edge:
  - Outputs go to 0: instr_rvalid_o, instr_rdata_o, last_addr_o, fetch_count_o, nop_count_o.
  - fifo_count_o goes to 0 and push_ready_o goes to 1.
  - instr_gnt_o goes to 0, since the FIFO is empty with STALL_ON_EMPTY=1; with STALL_ON_EMPTY=0 it follows instr_req_i.
- Reset mid-response drops the pending rvalid and loses any buffered words.
- Latency:
  - Push at edge N makes the word grantable in cycle N+1.
  - Grant in cycle T drives rvalid/rdata in cycle T+1.
  - Throughput is one word per cycle.
- Order: words return strictly in push order.
- Occupancy per cycle: fifo_count_o' = fifo_count_o + push - pop, bounded to 0..DEPTH. Underflow and overflow are structurally impossible.

## Test plan
- Basic fetch: push 32'h002180B3, then hold instr_req_i=1 -> gnt in the next cycle; rvalid=1 with rdata=32'h002180B3 one cycle later; fetch_count_o=1.
- Streaming: push 8 distinct words with DEPTH=8 and hold req -> push_ready_o=0 at full; 8 consecutive rvalid cycles return the words in order; fifo_count_o returns to 0.
- Empty stall: STALL_ON_EMPTY=1, req=1 with an empty FIFO for 5 cycles -> gnt=0 throughout; a push makes gnt=1 on the next cycle.
- NOP fill: STALL_ON_EMPTY=0, req with an empty FIFO -> rdata=32'h00000013 and nop_count_o increments per grant.
- Flush: buffer 3 words while a response is pending, then assert flush_i -> the pending rvalid still appears; fifo_count_o=0; no gnt in the flush cycle.
- Reset mid-stream: drop rst_ni during back-to-back grants -> all outputs 0 at the next edge; the counters restart from 0.

Source files
------------

// File: rtl/guvm_instr_feeder.sv
// Instruction-memory responder: buffers driver-pushed words in an in-order FIFO
// and returns one per granted core fetch over a req/gnt/rvalid handshake.
module guvm_instr_feeder #(
    parameter int          DEPTH          = 8,
    parameter bit          STALL_ON_EMPTY = 1'b1,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_valid_i,
    input  logic [31:0]                push_instr_i,
    output logic                       push_ready_o,
    input  logic                       flush_i,
    input  logic                       instr_req_i,
    input  logic [31:0]                instr_addr_i,
    output logic                       instr_gnt_o,
    output logic                       instr_rvalid_o,
    output logic [31:0]                instr_rdata_o,
    output logic [31:0]                last_addr_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic [15:0]                fetch_count_o,
    output logic [15:0]                nop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a word moves on push_valid_i && push_ready_o (held by the driver
    // otherwise); a fetch is accepted on instr_req_i && instr_gnt_o and its word
    // appears with instr_rvalid_o exactly one cycle later, never backpressured.
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     last_addr_q, last_addr_d;
    logic [15:0]     fetch_cnt_q, fetch_cnt_d;
    logic [15:0]     nop_cnt_q, nop_cnt_d;
    logic            full, empty, push, gnt, pop;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = push_valid_i && !full && !flush_i;
        gnt   = instr_req_i && !flush_i && (!empty || !STALL_ON_EMPTY);
        pop   = gnt && !empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        last_addr_d = last_addr_q;
        fetch_cnt_d = fetch_cnt_q;
        nop_cnt_d   = nop_cnt_q;
        state_d     = gnt ? RESP : IDLE;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        if (gnt) begin
            last_addr_d = instr_addr_i;
            fetch_cnt_d = fetch_cnt_q + 16'd1;
            if (empty) begin
                rdata_d   = NOP_INSTR;
                nop_cnt_d = nop_cnt_q + 16'd1;
            end else begin
                rdata_d = mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            last_addr_q <= '0;
            fetch_cnt_q <= '0;
            nop_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            last_addr_q <= last_addr_d;
            fetch_cnt_q <= fetch_cnt_d;
            nop_cnt_q   <= nop_cnt_d;
            if (push) mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    // The response-pending state is the rvalid flop itself.
    assign instr_rvalid_o = (state_q == RESP);
    assign instr_rdata_o  = rdata_q;
    assign instr_gnt_o    = gnt;
    assign push_ready_o   = !full;
    assign last_addr_o    = last_addr_q;
    assign fifo_count_o   = count_q;
    assign fetch_count_o  = fetch_cnt_q;
    assign nop_count_o    = nop_cnt_q;
endmodule

// File: tb/tb_guvm_instr_feeder.sv
// Bench for guvm_instr_feeder: stalling instance checked every cycle against a
// queue model, plus a NOP-fill instance checked with directed values.
module tb_guvm_instr_feeder;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push_valid, flush, req;
    logic [31:0]   push_data, addr;
    logic          push_ready, gnt, rvalid;
    logic [31:0]   rdata, last_addr;
    logic [CW-1:0] fifo_count;
    logic [15:0]   fetch_count, nop_count;

    logic          n_req;
    logic [31:0]   n_addr;
    logic          n_push_ready, n_gnt, n_rvalid;
    logic [31:0]   n_rdata, n_last_addr;
    logic [CW-1:0] n_fifo_count;
    logic [15:0]   n_fetch_count, n_nop_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] mdl_fifo[$];
    logic        m_rvalid;
    logic [31:0] m_last;
    logic [15:0] m_fetch;

    always #5 clk = ~clk;

    guvm_instr_feeder #(.DEPTH(DEPTH), .STALL_ON_EMPTY(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .push_valid_i(push_valid), .push_instr_i(push_data), .push_ready_o(push_ready),
        .flush_i(flush), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt), .instr_rvalid_o(rvalid), .instr_rdata_o(rdata),
        .last_addr_o(last_addr), .fifo_count_o(fifo_count),
        .fetch_count_o(fetch_count), .nop_count_o(nop_count)
    );

    guvm_instr_feeder #(.DEPTH(DEPTH), .STALL_ON_EMPTY(1'b0)) dut_nop (
        .clk_i(clk), .rst_ni(rst_n),
        .push_valid_i(1'b0), .push_instr_i(32'h0), .push_ready_o(n_push_ready),
        .flush_i(1'b0), .instr_req_i(n_req), .instr_addr_i(n_addr),
        .instr_gnt_o(n_gnt), .instr_rvalid_o(n_rvalid), .instr_rdata_o(n_rdata),
        .last_addr_o(n_last_addr), .fifo_count_o(n_fifo_count),
        .fetch_count_o(n_fetch_count), .nop_count_o(n_nop_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        push_valid = 1'b1;
        push_data  = w;
        step();
        push_valid = 1'b0;
    endtask

    // Per-cycle monitor: check against model state, then advance the model by the coming edge.
    always @(negedge clk) begin : monitor
        logic        e_gnt, e_push;
        logic [31:0] w;
        if (mon_en) begin
            e_gnt = req && !flush && (mdl_fifo.size() != 0);
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("push_ready", 32'(push_ready), 32'(mdl_fifo.size() != DEPTH));
            check("fifo_count", 32'(fifo_count), 32'(mdl_fifo.size()));
            check("rvalid", 32'(rvalid), 32'(m_rvalid));
            check("fetch_count", 32'(fetch_count), 32'(m_fetch));
            check("last_addr", last_addr, m_last);
            check("nop_count", 32'(nop_count), 32'h0);
            if (m_rvalid && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("rdata", rdata, w);
            end
            if (!rst_n) begin
                mdl_fifo.delete();
                exp_q.delete();
                m_rvalid = 1'b0;
                m_last   = '0;
                m_fetch  = '0;
            end else begin
                e_push = push_valid && (mdl_fifo.size() != DEPTH) && !flush;
                if (e_gnt) begin
                    exp_q.push_back(mdl_fifo.pop_front());
                    m_fetch = m_fetch + 16'd1;
                    m_last  = addr;
                end
                if (flush) mdl_fifo.delete();
                else if (e_push) mdl_fifo.push_back(push_data);
                m_rvalid = e_gnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; push_valid = 1'b0; push_data = '0; flush = 1'b0;
        req = 1'b0; addr = '0; n_req = 1'b0; n_addr = '0;
        m_rvalid = 1'b0; m_last = '0; m_fetch = '0;
        step();
        mon_en = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_nop_gnt", 32'(n_gnt), 32'h0);
        step();

        // NOP fill on the non-stalling instance
        n_req = 1'b1; n_addr = 32'h0000_1000;
        @(negedge clk);
        check("nop_gnt", 32'(n_gnt), 32'h1);
        check("nop_cnt0", 32'(n_nop_count), 32'h0);
        step();
        n_addr = 32'h0000_1004;
        @(negedge clk);
        check("nop_rvalid", 32'(n_rvalid), 32'h1);
        check("nop_rdata", n_rdata, 32'h0000_0013);
        check("nop_cnt1", 32'(n_nop_count), 32'h1);
        step();
        n_req = 1'b0;
        @(negedge clk);
        check("nop_cnt2", 32'(n_nop_count), 32'h2);
        check("nop_fetch2", 32'(n_fetch_count), 32'h2);
        check("nop_last", n_last_addr, 32'h0000_1004);
        check("nop_rdata2", n_rdata, 32'h0000_0013);
        step();

        // Basic fetch
        push_word(32'h002180B3);
        req = 1'b1; addr = 32'h0000_0080;
        step(); step();
        req = 1'b0;
        step();

        // Empty stall, then a push releases the grant
        req = 1'b1; addr = 32'h0000_0100;
        repeat (5) step();
        push_word(32'hCAFE_0001);
        step(); step();
        req = 1'b0;
        step();

        // Streaming through a full FIFO, including a refused push while full
        for (int i = 0; i < DEPTH; i++) push_word(32'hA000_0000 + 32'(i));
        push_valid = 1'b1; push_data = 32'hA000_0008;
        step();
        req = 1'b1;
        step();
        push_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            addr = 32'h0000_0200 + 32'(4 * i);
            step();
        end
        req = 1'b0;
        step();

        // Flush with a response pending and 3 words buffered
        for (int i = 0; i < 4; i++) push_word(32'hF100_0000 + 32'(i));
        req = 1'b1; addr = 32'h0000_0300;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; req = 1'b0;
        step(); step();

        // Randomised traffic
        for (int i = 0; i < 250; i++) begin
            push_valid = ($urandom_range(0, 2) != 0);
            push_data  = $urandom();
            req        = ($urandom_range(0, 2) != 0);
            addr       = $urandom();
            flush      = ($urandom_range(0, 15) == 0);
            step();
        end
        push_valid = 1'b0; flush = 1'b0; req = 1'b0;
        step();

        // Reset in the middle of back-to-back grants
        for (int i = 0; i < 5; i++) push_word(32'hB000_0000 + 32'(i));
        req = 1'b1; addr = 32'h0000_0400;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; req = 1'b0;
        @(negedge clk);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_nop_cnt", 32'(n_nop_count), 32'h0);
        step();
        push_word(32'hD000_0001);
        req = 1'b1; addr = 32'h0000_0500;
        step(); step();
        req = 1'b0;
        step(); step();

        mon_en = 1'b0;
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
